// File: rtl/aes_cbc_core_arbiter.sv
// Purpose: shares one iterative AES-256-CBC core between two AXI-Stream request channels, one whole packet at a time.
// Latency: one cycle from request tvalid (idle) to the first forwarded beat; while busy, both directions pass through combinationally.
// Backpressure: owner tready follows core tready and core-output tready follows the owner's sink; the non-owner is held with tready=0.
//
// Ports:
//   Clk, Rst            clock, synchronous active-high reset (shared with the core)
//   S0_axis_*, S1_axis_* request streams in (tdata/tkeep/tlast/tuser=enc/tvalid, tready out)
//   M0_axis_*, M1_axis_* result streams out (tready in)
//   Core_s_axis_*       stream into the core
//   Core_m_axis_*       stream out of the core
//   Busy                core currently owned by a channel
//   Owner               current or most recent owner index
//   Pkt_cnt0/1          completed-packet counters per channel (wrapping)
module aes_cbc_core_arbiter #(
    parameter int AXIS_WIDTH = 8,
    parameter int CNT_WIDTH  = 16,
    localparam int KEEP_WIDTH = (AXIS_WIDTH < 8) ? 1 : AXIS_WIDTH / 8
) (
    input  logic                  Clk,
    input  logic                  Rst,

    input  logic [AXIS_WIDTH-1:0] S0_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] S0_axis_tkeep,
    input  logic                  S0_axis_tlast,
    input  logic                  S0_axis_tuser,
    input  logic                  S0_axis_tvalid,
    output logic                  S0_axis_tready,

    input  logic [AXIS_WIDTH-1:0] S1_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] S1_axis_tkeep,
    input  logic                  S1_axis_tlast,
    input  logic                  S1_axis_tuser,
    input  logic                  S1_axis_tvalid,
    output logic                  S1_axis_tready,

    output logic [AXIS_WIDTH-1:0] M0_axis_tdata,
    output logic [KEEP_WIDTH-1:0] M0_axis_tkeep,
    output logic                  M0_axis_tlast,
    output logic                  M0_axis_tuser,
    output logic                  M0_axis_tvalid,
    input  logic                  M0_axis_tready,

    output logic [AXIS_WIDTH-1:0] M1_axis_tdata,
    output logic [KEEP_WIDTH-1:0] M1_axis_tkeep,
    output logic                  M1_axis_tlast,
    output logic                  M1_axis_tuser,
    output logic                  M1_axis_tvalid,
    input  logic                  M1_axis_tready,

    output logic [AXIS_WIDTH-1:0] Core_s_axis_tdata,
    output logic [KEEP_WIDTH-1:0] Core_s_axis_tkeep,
    output logic                  Core_s_axis_tlast,
    output logic                  Core_s_axis_tuser,
    output logic                  Core_s_axis_tvalid,
    input  logic                  Core_s_axis_tready,

    input  logic [AXIS_WIDTH-1:0] Core_m_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] Core_m_axis_tkeep,
    input  logic                  Core_m_axis_tlast,
    input  logic                  Core_m_axis_tuser,
    input  logic                  Core_m_axis_tvalid,
    output logic                  Core_m_axis_tready,

    output logic                  Busy,
    output logic                  Owner,
    output logic [CNT_WIDTH-1:0]  Pkt_cnt0,
    output logic [CNT_WIDTH-1:0]  Pkt_cnt1
);

    typedef struct packed {
        logic [AXIS_WIDTH-1:0] tdata;
        logic [KEEP_WIDTH-1:0] tkeep;
        logic                  tlast;
        logic                  tuser;
    } beat_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b01,
        ST_BUSY = 2'b10
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t state;
    state_t state_nxt;
    logic   last_grant;
    logic   grant;
    logic   pkt_done;

    beat_t  s0_beat;
    beat_t  s1_beat;
    beat_t  core_m_beat;
    beat_t  core_s_beat;
    beat_t  m0_beat;
    beat_t  m1_beat;

    assign s0_beat     = '{tdata: S0_axis_tdata, tkeep: S0_axis_tkeep, tlast: S0_axis_tlast, tuser: S0_axis_tuser};
    assign s1_beat     = '{tdata: S1_axis_tdata, tkeep: S1_axis_tkeep, tlast: S1_axis_tlast, tuser: S1_axis_tuser};
    assign core_m_beat = '{tdata: Core_m_axis_tdata, tkeep: Core_m_axis_tkeep,
                           tlast: Core_m_axis_tlast, tuser: Core_m_axis_tuser};

    assign Busy = (state == ST_BUSY);

    // Ownership ends on the core's final output beat, not on the request
    // tlast: the core interleaves per-block input and output phases.
    assign pkt_done = Busy && Core_m_axis_tvalid && Core_m_axis_tready && Core_m_axis_tlast;

    // Next state and grant. Arbitration looks only at tvalid and never
    // drives tready in idle, so there is no tvalid->tready path.
    always_comb begin
        state_nxt = state;
        grant     = Owner;
        case (state)
            ST_IDLE: begin
                if (S0_axis_tvalid || S1_axis_tvalid) begin
                    state_nxt = ST_BUSY;
                    if (S0_axis_tvalid && S1_axis_tvalid) begin
                        grant = ~last_grant;
                    end else begin
                        grant = S1_axis_tvalid;
                    end
                end
            end
            ST_BUSY: begin
                if (pkt_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= ST_IDLE;
            Owner      <= 1'b0;
            last_grant <= 1'b1;
            Pkt_cnt0   <= '0;
            Pkt_cnt1   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && state_nxt == ST_BUSY) begin
                Owner      <= grant;
                last_grant <= grant;
            end
            if (pkt_done) begin
                if (Owner) begin
                    Pkt_cnt1 <= Pkt_cnt1 + CNT_ONE;
                end else begin
                    Pkt_cnt0 <= Pkt_cnt0 + CNT_ONE;
                end
            end
        end
    end

    // Steering: everything idles at zero; while busy only the owner's
    // request and result streams are connected to the core.
    always_comb begin
        core_s_beat        = '0;
        Core_s_axis_tvalid = 1'b0;
        Core_m_axis_tready = 1'b0;
        S0_axis_tready     = 1'b0;
        S1_axis_tready     = 1'b0;
        m0_beat            = '0;
        m1_beat            = '0;
        M0_axis_tvalid     = 1'b0;
        M1_axis_tvalid     = 1'b0;
        if (Busy) begin
            if (Owner) begin
                core_s_beat        = s1_beat;
                Core_s_axis_tvalid = S1_axis_tvalid;
                S1_axis_tready     = Core_s_axis_tready;
                m1_beat            = core_m_beat;
                M1_axis_tvalid     = Core_m_axis_tvalid;
                Core_m_axis_tready = M1_axis_tready;
            end else begin
                core_s_beat        = s0_beat;
                Core_s_axis_tvalid = S0_axis_tvalid;
                S0_axis_tready     = Core_s_axis_tready;
                m0_beat            = core_m_beat;
                M0_axis_tvalid     = Core_m_axis_tvalid;
                Core_m_axis_tready = M0_axis_tready;
            end
        end
    end

    assign Core_s_axis_tdata = core_s_beat.tdata;
    assign Core_s_axis_tkeep = core_s_beat.tkeep;
    assign Core_s_axis_tlast = core_s_beat.tlast;
    assign Core_s_axis_tuser = core_s_beat.tuser;

    assign M0_axis_tdata = m0_beat.tdata;
    assign M0_axis_tkeep = m0_beat.tkeep;
    assign M0_axis_tlast = m0_beat.tlast;
    assign M0_axis_tuser = m0_beat.tuser;

    assign M1_axis_tdata = m1_beat.tdata;
    assign M1_axis_tkeep = m1_beat.tkeep;
    assign M1_axis_tlast = m1_beat.tlast;
    assign M1_axis_tuser = m1_beat.tuser;

endmodule

// File: tb/tb_aes_cbc_core_arbiter.sv
// Purpose: randomized bench for aes_cbc_core_arbiter with a stand-in block core and a packet-level reference model.
// Latency: inputs change on the falling edge; outputs are sampled 1 ns before the rising edge.
// Backpressure: sinks and the stand-in core apply random stalls; one test stalls a sink 2 cycles out of 3.
module tb_aes_cbc_core_arbiter;

    localparam int CW  = 2;
    localparam int BPB = 16;

    logic Clk;
    logic Rst;
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic [7:0] S0_axis_tdata, S1_axis_tdata, M0_axis_tdata, M1_axis_tdata;
    logic [0:0] S0_axis_tkeep, S1_axis_tkeep, M0_axis_tkeep, M1_axis_tkeep;
    logic S0_axis_tlast, S0_axis_tuser, S0_axis_tvalid, S0_axis_tready;
    logic S1_axis_tlast, S1_axis_tuser, S1_axis_tvalid, S1_axis_tready;
    logic M0_axis_tlast, M0_axis_tuser, M0_axis_tvalid, M0_axis_tready;
    logic M1_axis_tlast, M1_axis_tuser, M1_axis_tvalid, M1_axis_tready;
    logic [7:0] Core_s_axis_tdata, Core_m_axis_tdata;
    logic [0:0] Core_s_axis_tkeep, Core_m_axis_tkeep;
    logic Core_s_axis_tlast, Core_s_axis_tuser, Core_s_axis_tvalid, Core_s_axis_tready;
    logic Core_m_axis_tlast, Core_m_axis_tuser, Core_m_axis_tvalid, Core_m_axis_tready;
    logic Busy, Owner;
    logic [CW-1:0] Pkt_cnt0, Pkt_cnt1;

    aes_cbc_core_arbiter #(.AXIS_WIDTH(8), .CNT_WIDTH(CW)) dut (
        .Clk(Clk), .Rst(Rst),
        .S0_axis_tdata(S0_axis_tdata), .S0_axis_tkeep(S0_axis_tkeep), .S0_axis_tlast(S0_axis_tlast),
        .S0_axis_tuser(S0_axis_tuser), .S0_axis_tvalid(S0_axis_tvalid), .S0_axis_tready(S0_axis_tready),
        .S1_axis_tdata(S1_axis_tdata), .S1_axis_tkeep(S1_axis_tkeep), .S1_axis_tlast(S1_axis_tlast),
        .S1_axis_tuser(S1_axis_tuser), .S1_axis_tvalid(S1_axis_tvalid), .S1_axis_tready(S1_axis_tready),
        .M0_axis_tdata(M0_axis_tdata), .M0_axis_tkeep(M0_axis_tkeep), .M0_axis_tlast(M0_axis_tlast),
        .M0_axis_tuser(M0_axis_tuser), .M0_axis_tvalid(M0_axis_tvalid), .M0_axis_tready(M0_axis_tready),
        .M1_axis_tdata(M1_axis_tdata), .M1_axis_tkeep(M1_axis_tkeep), .M1_axis_tlast(M1_axis_tlast),
        .M1_axis_tuser(M1_axis_tuser), .M1_axis_tvalid(M1_axis_tvalid), .M1_axis_tready(M1_axis_tready),
        .Core_s_axis_tdata(Core_s_axis_tdata), .Core_s_axis_tkeep(Core_s_axis_tkeep),
        .Core_s_axis_tlast(Core_s_axis_tlast), .Core_s_axis_tuser(Core_s_axis_tuser),
        .Core_s_axis_tvalid(Core_s_axis_tvalid), .Core_s_axis_tready(Core_s_axis_tready),
        .Core_m_axis_tdata(Core_m_axis_tdata), .Core_m_axis_tkeep(Core_m_axis_tkeep),
        .Core_m_axis_tlast(Core_m_axis_tlast), .Core_m_axis_tuser(Core_m_axis_tuser),
        .Core_m_axis_tvalid(Core_m_axis_tvalid), .Core_m_axis_tready(Core_m_axis_tready),
        .Busy(Busy), .Owner(Owner), .Pkt_cnt0(Pkt_cnt0), .Pkt_cnt1(Pkt_cnt1)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       u;
    } beat_t;

    beat_t src_q [2][$];
    beat_t exp_q [2][$];
    bit    pres  [2];
    beat_t cur   [2];
    bit    m_rdy [2];
    int    rdy_mode [2];
    int    gaps;
    bit    core_stall;
    int    cyc;

    // Reference arbitration model: who owns the core, and completed counts.
    bit mdl_busy, mdl_owner, mdl_last;
    int mdl_cnt [2];

    // Stand-in core: collects 16-beat blocks; key(2), IV, then each text
    // block produces one 16-beat output block before the next is accepted.
    bit         cm_out, cm_user, cm_lastblk;
    int         cm_idx, cm_blk;
    logic [7:0] cm_key [32];
    logic [7:0] cm_chain [16];
    logic [7:0] cm_buf [16];
    logic [7:0] cm_obuf [16];

    bit prev_busy;
    int dut_grants[$];
    int cnt_log[$];
    int total, bad;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Build one packet on channel c and its expected result stream.
    task automatic gen_pkt(input int c, input int nblk, input bit enc);
        logic [7:0] key [32];
        logic [7:0] chain [16];
        logic [7:0] t [16];
        logic [7:0] o [16];
        for (int i = 0; i < 32; i++) begin
            key[i] = 8'($urandom);
            src_q[c].push_back('{d: key[i], l: 1'b0, u: enc});
        end
        for (int i = 0; i < BPB; i++) begin
            chain[i] = 8'($urandom);
            src_q[c].push_back('{d: chain[i], l: 1'b0, u: enc});
        end
        for (int b = 0; b < nblk; b++) begin
            for (int i = 0; i < BPB; i++) begin
                t[i] = 8'($urandom);
                o[i] = t[i] ^ chain[i] ^ key[i] ^ key[16+i];
                src_q[c].push_back('{d: t[i], l: (b == nblk-1 && i == BPB-1), u: enc});
                exp_q[c].push_back('{d: o[i], l: (b == nblk-1 && i == BPB-1), u: enc});
            end
            for (int i = 0; i < BPB; i++) chain[i] = enc ? o[i] : t[i];
        end
    endtask

    task automatic cycle(input bit rst_now);
        logic s_rdy [2];
        logic m_vld [2];
        logic [7:0] m_dat [2];
        logic m_lst [2], m_usr [2], m_kp [2];
        bit   o, exit_now;
        beat_t e;
        @(negedge Clk);
        Rst = rst_now;
        if (rst_now) begin
            for (int c = 0; c < 2; c++) begin
                src_q[c].delete();
                exp_q[c].delete();
                pres[c] = 1'b0;
            end
        end
        for (int c = 0; c < 2; c++) begin
            if (!pres[c] && src_q[c].size() > 0 && (gaps == 0 || $urandom_range(3) != 0)) begin
                pres[c] = 1'b1;
                cur[c]  = src_q[c][0];
            end
            case (rdy_mode[c])
                0:       m_rdy[c] = 1'b1;
                2:       m_rdy[c] = (cyc % 3 == 0);
                default: m_rdy[c] = 1'($urandom_range(1));
            endcase
        end
        S0_axis_tvalid = pres[0]; S0_axis_tdata = pres[0] ? cur[0].d : 8'h00;
        S0_axis_tlast  = pres[0] & cur[0].l; S0_axis_tuser = pres[0] & cur[0].u; S0_axis_tkeep = 1'b1;
        S1_axis_tvalid = pres[1]; S1_axis_tdata = pres[1] ? cur[1].d : 8'h00;
        S1_axis_tlast  = pres[1] & cur[1].l; S1_axis_tuser = pres[1] & cur[1].u; S1_axis_tkeep = 1'b1;
        M0_axis_tready = m_rdy[0];
        M1_axis_tready = m_rdy[1];
        Core_s_axis_tready = !cm_out && (!core_stall || $urandom_range(1) == 1);
        Core_m_axis_tvalid = cm_out;
        Core_m_axis_tdata  = cm_out ? cm_obuf[cm_idx] : 8'h00;
        Core_m_axis_tlast  = cm_out && cm_lastblk && (cm_idx == BPB-1);
        Core_m_axis_tuser  = cm_user;
        Core_m_axis_tkeep  = 1'b1;
        #4;
        s_rdy[0] = S0_axis_tready; s_rdy[1] = S1_axis_tready;
        m_vld[0] = M0_axis_tvalid; m_vld[1] = M1_axis_tvalid;
        m_dat[0] = M0_axis_tdata;  m_dat[1] = M1_axis_tdata;
        m_lst[0] = M0_axis_tlast;  m_lst[1] = M1_axis_tlast;
        m_usr[0] = M0_axis_tuser;  m_usr[1] = M1_axis_tuser;
        m_kp[0]  = M0_axis_tkeep;  m_kp[1]  = M1_axis_tkeep;
        o = mdl_owner;

        chk("busy", Busy, mdl_busy);
        chk("owner", Owner, mdl_owner);
        chk("cnt0", Pkt_cnt0, mdl_cnt[0]);
        chk("cnt1", Pkt_cnt1, mdl_cnt[1]);
        for (int c = 0; c < 2; c++) begin
            chk($sformatf("s%0d_rdy", c), s_rdy[c], mdl_busy && o == c && Core_s_axis_tready);
            chk($sformatf("m%0d_vld", c), m_vld[c], mdl_busy && o == c && cm_out);
        end
        chk("core_s_vld", Core_s_axis_tvalid, mdl_busy && pres[o]);
        chk("core_m_rdy", Core_m_axis_tready, mdl_busy && m_rdy[o]);
        if (Core_s_axis_tvalid === 1'b1) begin
            chk("core_s_dat", {Core_s_axis_tdata, Core_s_axis_tlast, Core_s_axis_tuser, Core_s_axis_tkeep},
                {cur[o].d, cur[o].l, cur[o].u, 1'b1});
        end
        if (!mdl_busy) begin
            chk("idle_dat", {Core_s_axis_tdata, M0_axis_tdata, M1_axis_tdata}, 0);
        end
        for (int c = 0; c < 2; c++) begin
            if (!Rst && m_vld[c] === 1'b1 && m_rdy[c]) begin
                if (exp_q[c].size() == 0) begin
                    chk($sformatf("m%0d_extra_beat", c), 1, 0);
                end else begin
                    e = exp_q[c].pop_front();
                    chk($sformatf("m%0d_dat", c), {m_dat[c], m_lst[c], m_usr[c], m_kp[c]}, {e.d, e.l, e.u, 1'b1});
                end
            end
        end
        if (Busy === 1'b1 && !prev_busy) dut_grants.push_back(int'(Owner));
        if (Busy === 1'b0 && prev_busy && Owner === 1'b0) cnt_log.push_back(int'(Pkt_cnt0));
        prev_busy = (Busy === 1'b1);

        exit_now = mdl_busy && cm_out && m_rdy[o] && Core_m_axis_tlast;
        if (Rst) begin
            mdl_busy = 1'b0; mdl_owner = 1'b0; mdl_last = 1'b1;
            mdl_cnt[0] = 0; mdl_cnt[1] = 0;
            cm_out = 1'b0; cm_idx = 0; cm_blk = 0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (pres[c] && s_rdy[c] === 1'b1) begin
                    void'(src_q[c].pop_front());
                    pres[c] = 1'b0;
                end
            end
            if (Core_s_axis_tvalid === 1'b1 && Core_s_axis_tready) begin
                cm_buf[cm_idx] = Core_s_axis_tdata;
                if (cm_idx == 0) cm_user = Core_s_axis_tuser;
                cm_idx++;
                if (cm_idx == BPB) begin
                    cm_idx = 0;
                    if (cm_blk < 2) begin
                        for (int i = 0; i < BPB; i++) cm_key[cm_blk*BPB+i] = cm_buf[i];
                    end else if (cm_blk == 2) begin
                        for (int i = 0; i < BPB; i++) cm_chain[i] = cm_buf[i];
                    end else begin
                        for (int i = 0; i < BPB; i++) begin
                            cm_obuf[i]  = cm_buf[i] ^ cm_chain[i] ^ cm_key[i] ^ cm_key[16+i];
                            cm_chain[i] = cm_user ? cm_obuf[i] : cm_buf[i];
                        end
                        cm_lastblk = Core_s_axis_tlast;
                        cm_out     = 1'b1;
                    end
                    cm_blk++;
                end
            end else if (cm_out && Core_m_axis_tready === 1'b1) begin
                cm_idx++;
                if (cm_idx == BPB) begin
                    cm_idx = 0;
                    cm_out = 1'b0;
                    if (cm_lastblk) cm_blk = 0;
                end
            end
            if (!mdl_busy) begin
                if (pres[0] || pres[1]) begin
                    mdl_owner = (S0_axis_tvalid && S1_axis_tvalid) ? !mdl_last : S1_axis_tvalid;
                    mdl_last  = mdl_owner;
                    mdl_busy  = 1'b1;
                end
            end else if (exit_now) begin
                mdl_busy = 1'b0;
                mdl_cnt[o] = (mdl_cnt[o] + 1) % (1 << CW);
            end
        end
        cyc++;
    endtask

    task automatic run_done(input int budget);
        int n = 0;
        while ((src_q[0].size() + src_q[1].size() + exp_q[0].size() + exp_q[1].size() > 0
                || pres[0] || pres[1] || mdl_busy) && n < budget) begin
            cycle(1'b0);
            n++;
        end
        if (n >= budget) chk("timeout", 1, 0);
        cycle(1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b1);
        cycle(1'b0);
    endtask

    initial begin : main
        int exp_cnt [5];
        int n;
        total = 0; bad = 0; cyc = 0;
        Rst = 1'b1;
        pres[0] = 0; pres[1] = 0; m_rdy[0] = 0; m_rdy[1] = 0;
        rdy_mode[0] = 1; rdy_mode[1] = 1; gaps = 1; core_stall = 1;
        mdl_busy = 0; mdl_owner = 0; mdl_last = 1; mdl_cnt[0] = 0; mdl_cnt[1] = 0;
        cm_out = 0; cm_idx = 0; cm_blk = 0; cm_user = 0; cm_lastblk = 0; prev_busy = 0;
        S0_axis_tvalid = 0; S1_axis_tvalid = 0; S0_axis_tdata = 0; S1_axis_tdata = 0;
        S0_axis_tlast = 0; S1_axis_tlast = 0; S0_axis_tuser = 0; S1_axis_tuser = 0;
        S0_axis_tkeep = 1; S1_axis_tkeep = 1; M0_axis_tready = 0; M1_axis_tready = 0;
        Core_s_axis_tready = 0; Core_m_axis_tvalid = 0; Core_m_axis_tdata = 0;
        Core_m_axis_tlast = 0; Core_m_axis_tuser = 0; Core_m_axis_tkeep = 1;

        cycle(1'b1);
        cycle(1'b0);
        chk("rst_busy", Busy, 0);
        chk("rst_owner", Owner, 0);
        chk("rst_cnt", {Pkt_cnt0, Pkt_cnt1}, 0);
        chk("rst_vld", {Core_s_axis_tvalid, M0_axis_tvalid, M1_axis_tvalid, S0_axis_tready, S1_axis_tready}, 0);

        // Channel 0 alone, single encrypt block.
        gen_pkt(0, 1, 1'b1);
        run_done(3000);
        chk("t1_cnt0", Pkt_cnt0, 1);
        chk("t1_cnt1", Pkt_cnt1, 0);

        // Both channels requesting right after reset: ch0 first, then ch1.
        do_reset();
        gaps = 0;
        dut_grants.delete();
        gen_pkt(0, 1, 1'b1);
        gen_pkt(1, 2, 1'b0);
        run_done(4000);
        chk("t2_ngrant", dut_grants.size(), 2);
        if (dut_grants.size() == 2) begin
            chk("t2_grant0", dut_grants[0], 0);
            chk("t2_grant1", dut_grants[1], 1);
        end

        // Three packets per channel, both always requesting: strict alternation.
        do_reset();
        dut_grants.delete();
        for (int k = 0; k < 3; k++) begin
            gen_pkt(0, $urandom_range(1, 2), 1'($urandom_range(1)));
            gen_pkt(1, $urandom_range(1, 2), 1'($urandom_range(1)));
        end
        run_done(12000);
        chk("t3_ngrant", dut_grants.size(), 6);
        for (int k = 0; k < 6 && k < dut_grants.size(); k++) chk($sformatf("t3_grant%0d", k), dut_grants[k], k % 2);
        chk("t3_cnt0", Pkt_cnt0, 3);
        chk("t3_cnt1", Pkt_cnt1, 3);

        // Ch1 four-block decrypt with its sink ready one cycle in three.
        gaps = 1;
        rdy_mode[1] = 2;
        gen_pkt(1, 4, 1'b0);
        run_done(6000);
        rdy_mode[1] = 1;
        chk("t4_cnt1_wrap", Pkt_cnt1, 0);
        chk("t4_cnt0", Pkt_cnt0, 3);

        // Reset in the middle of ch0's first text block, then a fresh ch1 packet.
        gen_pkt(0, 2, 1'b1);
        n = 0;
        while (!(cm_blk == 3 && cm_idx == 5 && !cm_out) && n < 3000) begin
            cycle(1'b0);
            n++;
        end
        if (n >= 3000) chk("t5_timeout", 1, 0);
        chk("t5_busy_before", Busy, 1);
        cycle(1'b1);
        cycle(1'b0);
        chk("t5_busy", Busy, 0);
        chk("t5_rdy_vld", {S0_axis_tready, S1_axis_tready, M0_axis_tvalid, M1_axis_tvalid,
                           Core_s_axis_tvalid, Core_m_axis_tready}, 0);
        chk("t5_cnt", {Pkt_cnt0, Pkt_cnt1}, 0);
        gen_pkt(1, 2, 1'b1);
        run_done(4000);
        chk("t5_cnt1", Pkt_cnt1, 1);
        chk("t5_cnt0", Pkt_cnt0, 0);

        // Five ch0 packets: the 2-bit counter must read 1,2,3,0,1.
        do_reset();
        cnt_log.delete();
        exp_cnt = '{1, 2, 3, 0, 1};
        for (int k = 0; k < 5; k++) gen_pkt(0, 1, 1'($urandom_range(1)));
        run_done(12000);
        chk("t6_nlog", cnt_log.size(), 5);
        for (int k = 0; k < 5 && k < cnt_log.size(); k++) chk($sformatf("t6_cnt%0d", k), cnt_log[k], exp_cnt[k]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
